pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Parametrised successor to the CPU's stage controller. Generates per-stage pipeline-register write enables, bubble inserts, RAM/register-file write strobes and the stage reset for an N-stage core. Two run modes: sequential (one stage active at a time, one instruction in flight) and overlapped pipelined mode with hazard stall, branch flush and a multi-cycle memory handshake. Sits beside the datapath top level; all pipeline registers and the PC take their enables from it.

## Interface
- NUM_STAGES, 5: number of stages; register i feeds stage i, register 0 is the PC/WB→IF register.
- MEM_STAGE, 3: index of the memory stage.
- WB_STAGE, 4: index of the write-back stage; must equal NUM_STAGES-1.
- FLUSH_DEPTH, 3: a flush squashes stages 0..FLUSH_DEPTH-1; must be ≤ MEM_STAGE.
- COUNT_WIDTH, 32: width of the retired-instruction counter.

- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE/HALTED; `mode` sampled on the same cycle.
- mode  in  1  0 = sequential, 1 = pipelined.
- hazard_stall  in  1  ID-stage data hazard; pipelined mode only.
- flush  in  1  taken redirect from MEM_STAGE; pipelined mode only.
- mem_ready  in  1  memory access complete this cycle.
- halt_req  in  1  stop at the next instruction boundary.
- stage_wren  out  NUM_STAGES  load enable per pipeline register.
- bubble  out  NUM_STAGES  register i loads a bubble (control fields zeroed); only meaningful with stage_wren[i].
- stage_valid  out  NUM_STAGES  stage i holds a live instruction.
- ram_wren  out  1  one-cycle memory write strobe.
- reg_wren  out  1  register-file write strobe.
- stage_reset  out  1  active-high clear for all pipeline registers.
- busy  out  1  state is RUN_SEQ, RUN_PIPE or DRAIN.
- halted  out  1  state is HALTED.
- retired  out  COUNT_WIDTH  instructions retired, wraps modulo 2^COUNT_WIDTH.

## Operation
- **States:** IDLE, INIT, RUN_SEQ, RUN_PIPE, DRAIN, HALTED.
  - IDLE/HALTED + start → INIT; `mode` is latched into `mode_q`.
  - INIT lasts 1 cycle, then goes to RUN_SEQ if mode_q=0, else RUN_PIPE.
- **Sequential mode:** a token t ∈ 0..N-1 marks the active stage, starting at 0. The active stage's valid bit is set.
  - Each cycle, stage_wren[(t+1) mod N]=1 and t advances, except when t=MEM_STAGE and mem_ready=0: then there is no wren and t holds.
  - ram_wren=1 on the first cycle only of t=MEM_STAGE.
  - reg_wren=1 on the cycle with t=WB_STAGE.
  - retired increments when t wraps WB→0.
  - halt_req is honoured only on the wrap cycle: go to HALTED, with t=0.
- **Pipelined mode:** valid[] is a shift register. Nominally all stage_wren=1, valid[0]=1 (fetch), valid[i]←valid[i-1]. Per-cycle priority:
  1. **mem_wait** (valid[MEM]&!mem_ready): regs 0..MEM_STAGE hold (wren=0); reg MEM_STAGE+1 loads a bubble; later regs advance. flush and hazard_stall are ignored this cycle.
  2. **flush:** reg 0 loads (redirect PC); regs 1..FLUSH_DEPTH load bubbles and their valid bits clear; later regs advance.
  3. **hazard_stall:** regs 0 and 1 hold; reg 2 loads a bubble; later regs advance.
- **Strobes in pipelined mode:**
  - ram_wren=1 only on the first cycle valid[MEM]=1 for a given instruction. Track this with an issued flag, cleared when the instruction advances.
  - reg_wren = valid[WB]. retired += valid[WB].
- **Drain:** halt_req in RUN_PIPE → DRAIN. In DRAIN, reg 0 holds and reg 1 loads bubbles, with no new fetch; stalls still apply. When all valid bits are 0 → HALTED.
- In IDLE and HALTED, all wren, bubble and strobes are 0.

## Timing
- **Reset:** while reset=1 at an edge, the next state is:
  - state=IDLE, t=0, mode_q=0, valid=0, retired=0;
  - stage_wren=0, bubble=0, ram_wren=0, reg_wren=0, busy=0, halted=0;
  - stage_reset=1.
- stage_reset is also 1 for the single INIT cycle; it is 0 otherwise.
- Reset mid-operation aborts in-flight instructions immediately, with no drain.
- All outputs are registered-state decodes. Strobes are combinational from state plus mem_ready, and valid in the same cycle.
- **Sequential latency:** NUM_STAGES cycles per instruction, plus k extra cycles for k cycles of mem_ready=0.
- **Pipelined throughput:** 1 instruction per cycle when there are no stalls. First retirement occurs NUM_STAGES cycles after INIT.
- `mode` is not re-sampled while busy.

## Test plan
- **Sequential, 3 instructions, mem_ready=1:** stage_wren walks 00010→00100→01000→10000→00001 in repeating 5-cycle periods. reg_wren fires at cycles 5, 10, 15 after INIT; retired=3 at cycle 15.
- **Sequential, mem_ready=0 for 2 cycles at MEM:** the token holds 2 cycles. ram_wren is high exactly 1 cycle. The instruction takes 7 cycles.
- **Pipelined, no hazards, 10 cycles after INIT:** valid=11111 from cycle 5. retired=6 at cycle 10.
- **Pipelined:**
  - hazard_stall for 1 cycle: wren[1:0]=00, bubble[2]=1.
  - flush: bubble[3:1]=111 and valid[2:0] cleared.
  - flush together with mem_wait: the flush is ignored.
- **halt_req in RUN_PIPE:** DRAIN lasts until valid=0, then HALTED. retired equals the number fetched before the halt.
- **reset asserted mid RUN_PIPE:** next cycle is IDLE, all outputs 0, stage_reset=1, retired=0.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
// Control and status bundle between the pipeline sequencer (slave side) and
// the core/datapath that drives its requests (master side).
interface pipeline_sequencer_if #(
    parameter int NUM_STAGES  = 5,
    parameter int COUNT_WIDTH = 32
);
    logic                   start;
    logic                   mode;
    logic                   hazard_stall;
    logic                   flush;
    logic                   mem_ready;
    logic                   halt_req;
    logic [NUM_STAGES-1:0]  stage_wren;
    logic [NUM_STAGES-1:0]  bubble;
    logic [NUM_STAGES-1:0]  stage_valid;
    logic                   ram_wren;
    logic                   reg_wren;
    logic                   stage_reset;
    logic                   busy;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] retired;

    modport master (
        output start, mode, hazard_stall, flush, mem_ready, halt_req,
        input  stage_wren, bubble, stage_valid, ram_wren, reg_wren,
               stage_reset, busy, halted, retired
    );

    modport slave (
        input  start, mode, hazard_stall, flush, mem_ready, halt_req,
        output stage_wren, bubble, stage_valid, ram_wren, reg_wren,
               stage_reset, busy, halted, retired
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stage controller for an N-stage core: sequential (one instruction in flight)
// or overlapped pipelined operation with stall, flush, memory wait and drain.
module pipeline_sequencer #(
    parameter int NUM_STAGES  = 5,
    parameter int MEM_STAGE   = 3,
    parameter int WB_STAGE    = 4,
    parameter int FLUSH_DEPTH = 3,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    pipeline_sequencer_if.slave seq_if
);
    localparam int TW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [TW-1:0]         MEM_T      = TW'(MEM_STAGE);
    localparam logic [TW-1:0]         WB_T       = TW'(WB_STAGE);
    localparam logic [NUM_STAGES-1:0] FETCH_ONLY = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        RUN_SEQ  = 3'd2,
        RUN_PIPE = 3'd3,
        DRAIN    = 3'd4,
        HALTED   = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          t_q, t_d, t_next_s;
    logic                   mode_q, mode_d;
    logic [NUM_STAGES-1:0]  valid_q, valid_d;
    logic                   issued_q, issued_d;
    logic [COUNT_WIDTH-1:0] retired_q;
    logic                   stage_reset_q;
    logic [NUM_STAGES-1:0]  wren_s, bubble_s;
    logic                   ram_wren_s, reg_wren_s, retire_s;
    logic                   mem_wait_s, fetch_s;

    assign t_next_s = (t_q == WB_T) ? {TW{1'b0}} : t_q + TW'(1);

    // Next-state and strobe decode from the registered state plus this cycle's inputs
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        mode_d     = mode_q;
        valid_d    = valid_q;
        issued_d   = 1'b0;
        wren_s     = {NUM_STAGES{1'b0}};
        bubble_s   = {NUM_STAGES{1'b0}};
        ram_wren_s = 1'b0;
        reg_wren_s = 1'b0;
        retire_s   = 1'b0;
        mem_wait_s = 1'b0;
        fetch_s    = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (seq_if.start) begin
                    state_d = INIT;
                    mode_d  = seq_if.mode;
                end else begin
                    state_d = state_q;
                end
            end
            INIT: begin
                t_d     = {TW{1'b0}};
                valid_d = FETCH_ONLY;
                state_d = mode_q ? RUN_PIPE : RUN_SEQ;
            end
            RUN_SEQ: begin
                mem_wait_s = (t_q == MEM_T) && !seq_if.mem_ready;
                ram_wren_s = (t_q == MEM_T) && !issued_q;
                reg_wren_s = (t_q == WB_T);
                if (mem_wait_s) begin
                    issued_d = 1'b1;
                end else begin
                    wren_s[t_next_s]  = 1'b1;
                    t_d               = t_next_s;
                    valid_d           = {NUM_STAGES{1'b0}};
                    valid_d[t_next_s] = 1'b1;
                    if (t_q == WB_T) begin
                        retire_s = 1'b1;
                        if (seq_if.halt_req) begin
                            state_d = HALTED;
                            t_d     = {TW{1'b0}};
                            valid_d = {NUM_STAGES{1'b0}};
                        end else begin
                            state_d = RUN_SEQ;
                        end
                    end else begin
                        retire_s = 1'b0;
                    end
                end
            end
            RUN_PIPE, DRAIN: begin
                // DRAIN stops fetching: PC holds and ID receives bubbles
                fetch_s    = (state_q == RUN_PIPE);
                mem_wait_s = valid_q[MEM_STAGE] && !seq_if.mem_ready;
                ram_wren_s = valid_q[MEM_STAGE] && !issued_q;
                reg_wren_s = valid_q[WB_STAGE];
                retire_s   = valid_q[WB_STAGE];
                wren_s     = {NUM_STAGES{1'b1}};
                valid_d    = {valid_q[NUM_STAGES-2:0], fetch_s};
                if (!fetch_s) begin
                    wren_s[0]   = 1'b0;
                    bubble_s[1] = 1'b1;
                    valid_d[1]  = 1'b0;
                end else begin
                    wren_s[0] = 1'b1;
                end
                if (mem_wait_s) begin
                    issued_d = 1'b1;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (i <= MEM_STAGE) begin
                            wren_s[i]   = 1'b0;
                            bubble_s[i] = 1'b0;
                            valid_d[i]  = valid_q[i];
                        end else if (i == MEM_STAGE + 1) begin
                            bubble_s[i] = 1'b1;
                            valid_d[i]  = 1'b0;
                        end else begin
                            wren_s[i] = 1'b1;
                        end
                    end
                end else if (seq_if.flush) begin
                    for (int i = 1; i <= FLUSH_DEPTH; i++) begin
                        bubble_s[i] = 1'b1;
                        valid_d[i]  = 1'b0;
                    end
                end else if (seq_if.hazard_stall) begin
                    wren_s[0]   = 1'b0;
                    wren_s[1]   = 1'b0;
                    bubble_s[1] = 1'b0;
                    valid_d[0]  = valid_q[0];
                    valid_d[1]  = valid_q[1];
                    bubble_s[2] = 1'b1;
                    valid_d[2]  = 1'b0;
                end else begin
                    issued_d = 1'b0;
                end
                if ((state_q == RUN_PIPE) && seq_if.halt_req) begin
                    state_d = DRAIN;
                end else if ((state_q == DRAIN) && (valid_q == {NUM_STAGES{1'b0}})) begin
                    state_d = HALTED;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, token, valid shift register and retire counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            t_q           <= {TW{1'b0}};
            mode_q        <= 1'b0;
            valid_q       <= {NUM_STAGES{1'b0}};
            issued_q      <= 1'b0;
            retired_q     <= {COUNT_WIDTH{1'b0}};
            stage_reset_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            mode_q        <= mode_d;
            valid_q       <= valid_d;
            issued_q      <= issued_d;
            retired_q     <= retired_q + COUNT_WIDTH'(retire_s);
            stage_reset_q <= (state_d == INIT);
        end
    end

    assign seq_if.stage_wren  = wren_s;
    assign seq_if.bubble      = bubble_s;
    assign seq_if.stage_valid = valid_q;
    assign seq_if.ram_wren    = ram_wren_s;
    assign seq_if.reg_wren    = reg_wren_s;
    assign seq_if.stage_reset = stage_reset_q;
    assign seq_if.busy        = (state_q == RUN_SEQ) || (state_q == RUN_PIPE) || (state_q == DRAIN);
    assign seq_if.halted      = (state_q == HALTED);
    assign seq_if.retired     = retired_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: sequential walk, memory wait,
// pipelined fill, stall/flush priority, drain to HALTED and mid-run reset.
module tb_pipeline_sequencer;
    typedef struct packed {
        logic [3:0] in;     // {hazard_stall, flush, mem_ready, halt_req}
        logic [4:0] wren;
        logic [4:0] bub;
        logic [4:0] val;
        logic       ram;
        logic       rg;
    } row_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [4:0] seq_wren_tbl [5];
    logic [4:0] seq_val_tbl  [5];
    row_t       seq2_tbl     [7];
    row_t       pipe_tbl     [24];

    pipeline_sequencer_if #(.NUM_STAGES(5), .COUNT_WIDTH(32)) bus ();

    pipeline_sequencer #(
        .NUM_STAGES(5), .MEM_STAGE(3), .WB_STAGE(4), .FLUSH_DEPTH(3), .COUNT_WIDTH(32)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .seq_if  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input logic exp_halted, input logic [31:0] exp_ret);
        check_value({tag, "_wren"},   bus.stage_wren, 32'd0);
        check_value({tag, "_bubble"}, bus.bubble,     32'd0);
        check_value({tag, "_valid"},  bus.stage_valid, 32'd0);
        check_value({tag, "_ram"},    bus.ram_wren,   32'd0);
        check_value({tag, "_reg"},    bus.reg_wren,   32'd0);
        check_value({tag, "_busy"},   bus.busy,       32'd0);
        check_value({tag, "_halted"}, bus.halted,     exp_halted);
        check_value({tag, "_retired"}, bus.retired,   exp_ret);
    endtask

    task automatic go(input logic m);
        bus.start = 1'b1;
        bus.mode  = m;
        cyc();
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        #1;
        check_value("init_stage_reset", bus.stage_reset, 32'd1);
        check_value("init_busy",        bus.busy,        32'd0);
        check_value("init_wren",        bus.stage_wren,  32'd0);
    endtask

    task automatic apply_row(input string tag, input row_t r);
        cyc();
        {bus.hazard_stall, bus.flush, bus.mem_ready, bus.halt_req} = r.in;
        #1;
        check_value({tag, "_wren"},   bus.stage_wren,  r.wren);
        check_value({tag, "_bubble"}, bus.bubble,      r.bub);
        check_value({tag, "_valid"},  bus.stage_valid, r.val);
        check_value({tag, "_ram"},    bus.ram_wren,    r.ram);
        check_value({tag, "_reg"},    bus.reg_wren,    r.rg);
        check_value({tag, "_busy"},   bus.busy,        32'd1);
        check_value({tag, "_srst"},   bus.stage_reset, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;
        seq_wren_tbl = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        seq_val_tbl  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        seq2_tbl[0] = '{4'b0010, 5'b00010, 5'b00000, 5'b00001, 1'b0, 1'b0};
        seq2_tbl[1] = '{4'b0010, 5'b00100, 5'b00000, 5'b00010, 1'b0, 1'b0};
        seq2_tbl[2] = '{4'b0010, 5'b01000, 5'b00000, 5'b00100, 1'b0, 1'b0};
        seq2_tbl[3] = '{4'b0000, 5'b00000, 5'b00000, 5'b01000, 1'b1, 1'b0};
        seq2_tbl[4] = '{4'b0000, 5'b00000, 5'b00000, 5'b01000, 1'b0, 1'b0};
        seq2_tbl[5] = '{4'b0010, 5'b10000, 5'b00000, 5'b01000, 1'b0, 1'b0};
        seq2_tbl[6] = '{4'b0011, 5'b00001, 5'b00000, 5'b10000, 1'b0, 1'b1};
        pipe_tbl[0]  = '{4'b0010, 5'b11111, 5'b00000, 5'b00001, 1'b0, 1'b0};
        pipe_tbl[1]  = '{4'b0010, 5'b11111, 5'b00000, 5'b00011, 1'b0, 1'b0};
        pipe_tbl[2]  = '{4'b0010, 5'b11111, 5'b00000, 5'b00111, 1'b0, 1'b0};
        pipe_tbl[3]  = '{4'b0010, 5'b11111, 5'b00000, 5'b01111, 1'b1, 1'b0};
        for (int i = 4; i <= 9; i++) begin
            pipe_tbl[i] = '{4'b0010, 5'b11111, 5'b00000, 5'b11111, 1'b1, 1'b1};
        end
        pipe_tbl[10] = '{4'b1010, 5'b11100, 5'b00100, 5'b11111, 1'b1, 1'b1};
        pipe_tbl[11] = '{4'b0110, 5'b11111, 5'b01110, 5'b11011, 1'b1, 1'b1};
        pipe_tbl[12] = '{4'b0010, 5'b11111, 5'b00000, 5'b10001, 1'b0, 1'b1};
        pipe_tbl[13] = '{4'b0010, 5'b11111, 5'b00000, 5'b00011, 1'b0, 1'b0};
        pipe_tbl[14] = '{4'b0010, 5'b11111, 5'b00000, 5'b00111, 1'b0, 1'b0};
        pipe_tbl[15] = '{4'b0100, 5'b10000, 5'b10000, 5'b01111, 1'b1, 1'b0};
        pipe_tbl[16] = '{4'b0000, 5'b10000, 5'b10000, 5'b01111, 1'b0, 1'b0};
        pipe_tbl[17] = '{4'b0010, 5'b11111, 5'b00000, 5'b01111, 1'b0, 1'b0};
        pipe_tbl[18] = '{4'b0011, 5'b11111, 5'b00000, 5'b11111, 1'b1, 1'b1};
        pipe_tbl[19] = '{4'b0010, 5'b11110, 5'b00010, 5'b11111, 1'b1, 1'b1};
        pipe_tbl[20] = '{4'b0010, 5'b11110, 5'b00010, 5'b11100, 1'b1, 1'b1};
        pipe_tbl[21] = '{4'b0010, 5'b11110, 5'b00010, 5'b11000, 1'b1, 1'b1};
        pipe_tbl[22] = '{4'b0010, 5'b11110, 5'b00010, 5'b10000, 1'b0, 1'b1};
        pipe_tbl[23] = '{4'b0010, 5'b11110, 5'b00010, 5'b00000, 1'b0, 1'b0};

        bus.start        = 1'b0;
        bus.mode         = 1'b0;
        bus.hazard_stall = 1'b0;
        bus.flush        = 1'b0;
        bus.mem_ready    = 1'b1;
        bus.halt_req     = 1'b0;

        // Reset state, then first idle cycle after release
        cyc();
        cyc();
        check_value("rst_stage_reset", bus.stage_reset, 32'd1);
        check_quiet("rst", 1'b0, 32'd0);
        reset = 1'b0;
        cyc();
        check_value("idle_stage_reset", bus.stage_reset, 32'd0);
        check_quiet("idle", 1'b0, 32'd0);

        // Sequential, three instructions, memory always ready
        go(1'b0);
        for (int c = 1; c <= 15; c++) begin
            r.in   = {3'b001, (c == 15)};
            r.wren = seq_wren_tbl[(c - 1) % 5];
            r.bub  = 5'b00000;
            r.val  = seq_val_tbl[(c - 1) % 5];
            r.ram  = ((c - 1) % 5 == 3);
            r.rg   = ((c - 1) % 5 == 4);
            apply_row($sformatf("seq1_c%0d", c), r);
        end
        cyc();
        bus.halt_req = 1'b0;
        #1;
        check_quiet("seq1_halted", 1'b1, 32'd3);

        // Sequential with two cycles of memory wait at the MEM stage
        go(1'b0);
        for (int c = 1; c <= 7; c++) begin
            apply_row($sformatf("seq2_c%0d", c), seq2_tbl[c - 1]);
        end
        cyc();
        bus.halt_req  = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check_quiet("seq2_halted", 1'b1, 32'd4);

        // Pipelined: fill, hazard, flush, flush under mem wait, drain
        go(1'b1);
        for (int c = 1; c <= 24; c++) begin
            apply_row($sformatf("pipe_c%0d", c), pipe_tbl[c - 1]);
            if (c == 11) begin
                check_value("pipe_retired_after_fill", bus.retired, 32'd10);
            end
        end
        cyc();
        {bus.hazard_stall, bus.flush, bus.mem_ready, bus.halt_req} = 4'b0010;
        #1;
        check_quiet("pipe_halted", 1'b1, 32'd18);

        // Reset in the middle of pipelined operation
        go(1'b1);
        for (int c = 1; c <= 6; c++) begin
            cyc();
        end
        check_value("midrst_busy_before", bus.busy, 32'd1);
        reset = 1'b1;
        cyc();
        check_value("midrst_stage_reset", bus.stage_reset, 32'd1);
        check_quiet("midrst", 1'b0, 32'd0);
        reset = 1'b0;
        cyc();
        check_value("midrst_release_srst", bus.stage_reset, 32'd0);
        check_quiet("midrst_idle", 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
